fiber_link_monitor: RTL

- Parametrised multi-channel fibre link-loss monitor for the power-unit board.
- Each channel watches an idle-high fibre receive line (comm_r) and flags a link error when the line stays high for TIMEOUT_US microseconds. Time is counted in ticks of the shared time_1us strobe.
- Adds features the single-channel delay detector lacks: per-channel masking, a latched or auto-recover mode with a recovery window, first-fault channel capture and a saturating fault-event counter.
- Sits between the fibre receivers and the protection/fault-aggregation logic.

---
 rtl/fiber_link_monitor_if.sv | 20 ++
 rtl/fiber_link_monitor.sv | 112 +++++++++++
 2 files changed

// File: rtl/fiber_link_monitor_if.sv
// fiber_link_monitor_if: fibre receive inputs and fault-status outputs of the link monitor
interface fiber_link_monitor_if #(parameter int CH_NUM = 4);
  logic              time_1us;
  logic              reset_unit;
  logic [CH_NUM-1:0] comm_r;
  logic [CH_NUM-1:0] ch_mask;
  logic [CH_NUM-1:0] link_err;
  logic              any_err;
  logic              first_err_vld;
  logic [3:0]        first_err_ch;
  logic [7:0]        err_event_cnt;
  modport master (
    output time_1us, reset_unit, comm_r, ch_mask,
    input  link_err, any_err, first_err_vld, first_err_ch, err_event_cnt
  );
  modport slave (
    input  time_1us, reset_unit, comm_r, ch_mask,
    output link_err, any_err, first_err_vld, first_err_ch, err_event_cnt
  );
endinterface

// File: rtl/fiber_link_monitor.sv
// fiber_link_monitor: per-channel fibre idle-high timeout detector with masking, recovery,
// first-fault capture and a saturating fault-event counter
module fiber_link_monitor #(
  parameter int CH_NUM     = 4,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT_US = 20,
  parameter int RECOVER_US = 5,
  parameter bit LATCH      = 1'b1
) (
  input logic                clk,
  input logic                rst,
  fiber_link_monitor_if.slave bus
);
  typedef enum logic [1:0] {OK, PEND, FAULT, RECOV} state_e;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RECOVER_US - 1);
  logic [2:0]        t_q;
  logic [CH_NUM-1:0] c_meta_q, comm_s_q;
  state_e            st_q [CH_NUM];
  state_e            st_d [CH_NUM];
  logic [CNT_W-1:0]  cnt_q [CH_NUM];
  logic [CNT_W-1:0]  cnt_d [CH_NUM];
  logic [CH_NUM-1:0] pf, link_err_d, link_err_q;
  logic              any_err_q, first_vld_q, first_vld_d;
  logic [3:0]        first_ch_q, first_ch_d, pf_idx;
  logic [7:0]        evt_q, evt_d;
  logic              tick;
  // falling edge of the synchronised 1 us strobe
  assign tick = t_q[2] & ~t_q[1];
  always_comb begin
    pf = '0;
    link_err_d = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (bus.reset_unit || bus.ch_mask[i]) begin
        st_d[i] = OK;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          OK: if (comm_s_q[i]) begin
            st_d[i] = PEND;
            cnt_d[i] = '0;
          end
          PEND: if (!comm_s_q[i]) begin
            st_d[i] = OK;
            cnt_d[i] = '0;
          end else if (tick) begin
            st_d[i] = (cnt_q[i] == TO_LAST) ? FAULT : PEND;
            cnt_d[i] = (cnt_q[i] == TO_LAST) ? '0 : cnt_q[i] + CNT_W'(1);
            pf[i] = (cnt_q[i] == TO_LAST);
          end
          FAULT: if (!LATCH && !comm_s_q[i]) begin
            st_d[i] = RECOV;
            cnt_d[i] = '0;
          end
          RECOV: if (comm_s_q[i]) begin
            st_d[i] = FAULT;
            cnt_d[i] = '0;
          end else if (tick) begin
            st_d[i] = (cnt_q[i] == RC_LAST) ? OK : RECOV;
            cnt_d[i] = (cnt_q[i] == RC_LAST) ? '0 : cnt_q[i] + CNT_W'(1);
          end
          default: begin
            st_d[i] = OK;
            cnt_d[i] = '0;
          end
        endcase
      end
      link_err_d[i] = (st_d[i] == FAULT) || (st_d[i] == RECOV);
    end
  end
  always_comb begin
    pf_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) if (pf[i]) pf_idx = 4'(i);
    first_vld_d = bus.reset_unit ? 1'b0 : first_vld_q | (|pf);
    first_ch_d  = bus.reset_unit ? 4'd0 : (!first_vld_q && |pf) ? pf_idx : first_ch_q;
    evt_d       = (|pf && evt_q != 8'hFF) ? evt_q + 8'd1 : evt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q         <= '0;
      c_meta_q    <= '0;
      comm_s_q    <= '0;
      link_err_q  <= '0;
      any_err_q   <= 1'b0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
      evt_q       <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        st_q[i]  <= OK;
        cnt_q[i] <= '0;
      end
    end else begin
      t_q         <= {t_q[1:0], bus.time_1us};
      c_meta_q    <= bus.comm_r;
      comm_s_q    <= c_meta_q;
      link_err_q  <= link_err_d;
      any_err_q   <= |link_err_d;
      first_vld_q <= first_vld_d;
      first_ch_q  <= first_ch_d;
      evt_q       <= evt_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
    end
  end
  assign bus.link_err      = link_err_q;
  assign bus.any_err       = any_err_q;
  assign bus.first_err_vld = first_vld_q;
  assign bus.first_err_ch  = first_ch_q;
  assign bus.err_event_cnt = evt_q;
endmodule
